// File: rtl/fifo_pkt_pkg.sv
// Shared packet framing definitions for the FIFO packet writer and reader.
// Header layout: LEN at [LEN_W-1:0], SEQ at [LEN_W+7:LEN_W], MAGIC at [LEN_W+15:LEN_W+8].
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    TRAIL = 2'd3
  } pkt_state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         LEN_LSB       = 0;

  function automatic int seq_lsb(input int len_w);
    return len_w;
  endfunction

  function automatic int magic_lsb(input int len_w);
    return len_w + 8;
  endfunction

  // Returns a 64-bit container; callers truncate it to their FIFO width.
  function automatic logic [63:0] pack_hdr(input logic [7:0]  magic,
                                           input logic [7:0]  seq,
                                           input logic [63:0] len,
                                           input int          len_w);
    logic [63:0] mask;
    mask = (64'd1 << len_w) - 64'd1;
    return ({56'd0, magic} << magic_lsb(len_w)) |
           ({56'd0, seq} << seq_lsb(len_w)) |
           ((len & mask) << LEN_LSB);
  endfunction

endpackage

// File: rtl/fifo_pkt_writer.sv
// Write-domain packet framer: header, payload beats and XOR-checksum trailer
// pushed into the asy_fifo write port.
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter int         WIDTH = 32,
  parameter int         LEN_W = 16,
  parameter logic [7:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             pkt_done,
  output logic [7:0]       seq,
  output logic [1:0]       dbg_state
);

  // Handshakes: a command transfers on cmd_valid & cmd_ready, a payload beat
  // on in_valid & in_ready; wr_en is only raised when fifo_full is low, so
  // every wr_en cycle is a committed FIFO write.
  pkt_state_t       state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] beat_cnt;
  logic [WIDTH-1:0] csum;
  logic             beat_acc;

  assign beat_acc  = (state == DATA) && in_valid && !fifo_full;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= IDLE;
      seq      <= 8'd0;
      len_r    <= '0;
      beat_cnt <= '0;
      csum     <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            len_r    <= cmd_len;
            csum     <= '0;
            beat_cnt <= '0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (!fifo_full) state <= (len_r == '0) ? TRAIL : DATA;
        end
        DATA: begin
          if (beat_acc) begin
            csum     <= csum ^ in_data;
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (beat_cnt == len_r - LEN_W'(1)) state <= TRAIL;
          end
        end
        TRAIL: begin
          if (!fifo_full) begin
            pkt_done <= 1'b1;
            seq      <= seq + 8'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write port is combinational so a deasserting fifo_full is used the same cycle.
  always_comb begin
    wr_en    = 1'b0;
    in_ready = 1'b0;
    wr_data  = '0;
    case (state)
      HDR: begin
        wr_en   = !fifo_full;
        wr_data = WIDTH'(pack_hdr(MAGIC, seq, 64'(len_r), LEN_W));
      end
      DATA: begin
        in_ready = !fifo_full;
        wr_en    = in_valid && !fifo_full;
        wr_data  = in_data;
      end
      TRAIL: begin
        wr_en   = !fifo_full;
        wr_data = csum;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed and randomized bench for fifo_pkt_writer with a packet-level reference model.
module tb_fifo_pkt_writer;
  import fifo_pkt_pkg::*;

  localparam int WIDTH = 32;
  localparam int LEN_W = 16;

  logic             wr_clk    = 1'b0;
  logic             wr_rst_n  = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len   = '0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             fifo_full = 1'b0;
  logic             cmd_ready, in_ready, wr_en, busy, pkt_done;
  logic [WIDTH-1:0] wr_data;
  logic [7:0]       seq;
  logic [1:0]       dbg_state;

  fifo_pkt_writer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .MAGIC(8'hA5)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .pkt_done(pkt_done), .seq(seq), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / stall generation ----------------
  always #5 wr_clk = ~wr_clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   in_ready_cycles = 0;
  logic force_full  = 1'b0;
  logic rand_stall  = 1'b0;
  logic [WIDTH-1:0] obs_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pay_q[$];
  logic [7:0]       seq_model = 8'd0;
  int   acc_cyc  = 0;
  int   done_cyc = 0;

  always @(posedge wr_clk) cyc <= cyc + 1;

  always @(posedge wr_clk) begin
    #2;
    fifo_full = force_full | (rand_stall & ($urandom_range(0, 3) == 0));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard capture ----------------
  always @(negedge wr_clk) begin
    if (wr_rst_n) begin
      check("no_write_when_full", 64'(wr_en & fifo_full), 64'd0);
      check("in_ready_only_in_data", 64'(in_ready & (fifo_full | ~busy)), 64'd0);
      if (wr_en) obs_q.push_back(wr_data);
      if (in_ready) in_ready_cycles++;
    end
  end

  // ---------------- reference model ----------------
  task automatic build_expected(input int len);
    logic [WIDTH-1:0] x;
    x = '0;
    exp_q.delete();
    exp_q.push_back({8'h00, 8'hA5, seq_model, 16'(len)});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay_q[i]);
      x = x ^ pay_q[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_word_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
  endtask

  task automatic fill_random(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back($urandom);
  endtask

  // ---------------- drivers ----------------
  task automatic issue_cmd(input int len);
    logic r;
    int   t;
    r = 1'b0;
    t = 0;
    cmd_len   = 16'(len);
    cmd_valid = 1'b1;
    while (!r && t < 200) begin
      @(negedge wr_clk);
      r = cmd_ready;
      if (r) acc_cyc = cyc;
      @(posedge wr_clk); #1;
      t++;
    end
    cmd_valid = 1'b0;
    if (!r) check("cmd_timeout", 64'd1, 64'd0);
  endtask

  task automatic push_beats(input int nbeats, input bit bubbles, input int stall_at, input bit spurious);
    logic acc;
    int   t;
    for (int i = 0; i < nbeats; i++) begin
      in_data = pay_q[i];
      if (i == stall_at) begin
        in_valid   = 1'b1;
        force_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge wr_clk);
          check("stall_wr_en", 64'(wr_en), 64'd0);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_wr_data", 64'(wr_data), 64'(pay_q[i]));
          check("stall_busy", 64'(busy), 64'd1);
          @(posedge wr_clk); #1;
        end
        force_full = 1'b0;
      end
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 1000) begin
        in_valid = !(bubbles && ($urandom_range(0, 2) == 0));
        if (spurious) begin
          cmd_valid = 1'b1;
          cmd_len   = LEN_W'($urandom);
        end
        @(negedge wr_clk);
        acc = in_valid && in_ready;
        if (spurious) check("cmd_ready_while_busy", 64'(cmd_ready), 64'd0);
        @(posedge wr_clk); #1;
        t++;
      end
      if (!acc) begin
        check("beat_timeout", 64'd1, 64'd0);
        break;
      end
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    int   t;
    seen = 1'b0;
    t    = 0;
    while (!seen && t < 1000) begin
      @(negedge wr_clk);
      if (pkt_done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
      @(posedge wr_clk); #1;
      t++;
    end
    if (!seen) check("done_timeout", 64'd1, 64'd0);
    @(negedge wr_clk);
    check("pkt_done_one_cycle", 64'(pkt_done), 64'd0);
    @(posedge wr_clk); #1;
  endtask

  task automatic run_pkt(input string tag, input int len, input bit bubbles,
                         input int stall_at, input bit spurious, input bit chk_lat);
    build_expected(len);
    issue_cmd(len);
    push_beats(len, bubbles, stall_at, spurious);
    wait_done();
    seq_model = seq_model + 8'd1;
    if (chk_lat) check({tag, "_latency"}, 64'(done_cyc - acc_cyc), 64'(len + 3));
    compare_stream(tag);
    check({tag, "_seq"}, 64'(seq), 64'(seq_model));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_seq"}, 64'(seq), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int ic;
    #3 wr_rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;
    wr_rst_n = 1'b1;

    // three-beat packet, fixed payload, no stalls
    pay_q.delete();
    pay_q.push_back(32'h11);
    pay_q.push_back(32'h22);
    pay_q.push_back(32'h44);
    run_pkt("len3", 3, 1'b0, -1, 1'b0, 1'b1);

    // empty packet: header then zero trailer, payload port never opens
    pay_q.delete();
    ic = in_ready_cycles;
    run_pkt("len0", 0, 1'b0, -1, 1'b0, 1'b1);
    check("len0_in_ready_never", 64'(in_ready_cycles - ic), 64'd0);

    // five-cycle FIFO stall after the second beat
    fill_random(4);
    run_pkt("stall", 4, 1'b0, 2, 1'b0, 1'b0);

    // back-to-back single-beat packets across the seq wrap, with spurious commands
    for (int p = 0; p < 257; p++) begin
      fill_random(1);
      run_pkt("b2b", 1, 1'b0, -1, 1'b1, 1'b0);
    end

    // reset after two of five beats
    fill_random(5);
    build_expected(5);
    issue_cmd(5);
    push_beats(2, 1'b0, -1, 1'b0);
    wr_rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    check("midrst_partial_count", 64'(obs_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) check("midrst_partial_word", 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;
    wr_rst_n  = 1'b1;
    seq_model = 8'd0;
    fill_random(2);
    run_pkt("after_rst", 2, 1'b0, -1, 1'b0, 1'b1);

    // random lengths, random FIFO stalls and payload bubbles
    rand_stall = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(0, 9);
      fill_random(len);
      run_pkt("rand", len, 1'b1, -1, 1'b0, 1'b0);
    end
    rand_stall = 1'b0;
    @(posedge wr_clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
